// File: rtl/pipe_stage_chain.sv
// Bubble-collapsing valid/ready register pipeline of DEPTH stages.
// An optional one-entry skid register at the front makes rdy_a a registered signal.
module pipe_stage_chain #(
  parameter int unsigned WIDTH = 32,
  parameter int unsigned DEPTH = 2,
  parameter int unsigned SKID  = 1
) (
  input  logic                        clk,
  input  logic                        rst,
  input  logic                        flush,
  input  logic [WIDTH-1:0]            data_a,
  input  logic                        vld_a,
  output logic                        rdy_a,
  output logic [WIDTH-1:0]            data_b,
  output logic                        vld_b,
  input  logic                        rdy_b,
  output logic [$clog2(DEPTH+2)-1:0]  count
);

  localparam int unsigned CW = $clog2(DEPTH+2);
  localparam int unsigned DW = DEPTH * WIDTH;

  logic [DEPTH-1:0][WIDTH-1:0] data_q, data_d, up_data;
  logic [DEPTH-1:0]            vld_q, vld_d, up_vld, rdy_s;
  logic                        skid_vld_q, skid_vld_d;
  logic [WIDTH-1:0]            skid_data_q, skid_data_d;
  logic                        src_vld;
  logic [WIDTH-1:0]            src_data;
  logic [CW-1:0]               count_q, count_d;

  // A stage can advance if any stage at or after it is empty, or the sink takes the head.
  for (genvar g = 0; g < DEPTH; g++) begin : g_rdy
    assign rdy_s[g]  = rdy_b | ~(&vld_q[DEPTH-1:g]);
    assign data_d[g] = (rdy_s[g] && up_vld[g]) ? up_data[g] : data_q[g];
  end

  // Each stage's upstream is the previous stage; stage 0 sees the source mux.
  assign up_vld  = DEPTH'({vld_q, src_vld});
  assign up_data = DW'({data_q, src_data});

  always_comb begin
    src_vld     = vld_a;
    src_data    = data_a;
    rdy_a       = rdy_s[0] & ~flush;
    skid_vld_d  = 1'b0;
    skid_data_d = skid_data_q;
    if (SKID != 0) begin
      rdy_a    = ~skid_vld_q & ~flush;
      src_vld  = skid_vld_q | vld_a;
      src_data = skid_vld_q ? skid_data_q : data_a;
      if (skid_vld_q) begin
        skid_vld_d = ~rdy_s[0];
      end else if (vld_a && rdy_a && !rdy_s[0]) begin
        skid_vld_d  = 1'b1;
        skid_data_d = data_a;
      end
      if (flush) begin
        skid_vld_d = 1'b0;
      end
    end
    vld_d = (rdy_s & up_vld) | (~rdy_s & vld_q);
    if (flush) begin
      vld_d = '0;
    end
    count_d = CW'($countones(vld_d)) + CW'(skid_vld_d);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      vld_q       <= '0;
      data_q      <= '0;
      skid_vld_q  <= 1'b0;
      skid_data_q <= '0;
      count_q     <= '0;
    end else begin
      vld_q       <= vld_d;
      data_q      <= data_d;
      skid_vld_q  <= skid_vld_d;
      skid_data_q <= skid_data_d;
      count_q     <= count_d;
    end
  end

  assign data_b = data_q[DEPTH-1];
  assign vld_b  = vld_q[DEPTH-1];
  assign count  = count_q;

endmodule

// File: tb/tb_pipe_stage_chain.sv
// Directed bench: one SKID=1 chain and one SKID=0 chain, both DEPTH=2, WIDTH=8.
module tb_pipe_stage_chain;

  logic       clk = 1'b0;
  logic       rst;
  logic       flush, vld_a, rdy_a, vld_b, rdy_b;
  logic [7:0] data_a, data_b;
  logic [1:0] count;
  logic       flush_0, vld_a_0, rdy_a_0, vld_b_0, rdy_b_0;
  logic [7:0] data_a_0, data_b_0;
  logic [1:0] count_0;

  int errors = 0;
  int checks = 0;

  always #5 clk = ~clk;

  pipe_stage_chain #(.WIDTH(8), .DEPTH(2), .SKID(1)) dut (
    .clk(clk), .rst(rst), .flush(flush),
    .data_a(data_a), .vld_a(vld_a), .rdy_a(rdy_a),
    .data_b(data_b), .vld_b(vld_b), .rdy_b(rdy_b),
    .count(count)
  );

  pipe_stage_chain #(.WIDTH(8), .DEPTH(2), .SKID(0)) dut0 (
    .clk(clk), .rst(rst), .flush(flush_0),
    .data_a(data_a_0), .vld_a(vld_a_0), .rdy_a(rdy_a_0),
    .data_b(data_b_0), .vld_b(vld_b_0), .rdy_b(rdy_b_0),
    .count(count_0)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  initial begin
    rst = 1'b1; flush = 1'b0; vld_a = 1'b1; data_a = 8'h99; rdy_b = 1'b0;
    flush_0 = 1'b0; vld_a_0 = 1'b0; data_a_0 = 8'h00; rdy_b_0 = 1'b0;

    // Reset held two edges with an offer pending
    tick();
    chk("rst1_count", count, 0);
    chk("rst1_vldb", vld_b, 0);
    tick();
    chk("rst2_count", count, 0);
    rst = 1'b0; vld_a = 1'b0;
    #1;
    chk("rel_rdya", rdy_a, 1);
    chk("rel_vldb", vld_b, 0);
    chk("rel_count", count, 0);
    chk("rel_rdya0", rdy_a_0, 1);
    chk("rel_count0", count_0, 0);
    tick();
    chk("rel_noacc_count", count, 0);
    chk("rel_noacc_vldb", vld_b, 0);

    // Streaming 1..8 with rdy_b=1
    rdy_b = 1'b1;
    for (int c = 0; c < 12; c++) begin
      vld_a  = (c < 8);
      data_a = 8'(c + 1);
      #1;
      chk("strm_rdya", rdy_a, 1);
      chk("strm_vldb", vld_b, (c >= 2 && c < 10));
      if (c >= 2 && c < 10) chk("strm_data", data_b, c - 1);
      tick();
    end

    // Backpressure: A,B,C accepted, D held until drain
    rdy_b = 1'b0;
    vld_a = 1'b1; data_a = 8'h0A; #1;
    chk("bp0_rdya", rdy_a, 1);
    tick();
    data_a = 8'h0B; #1;
    chk("bp1_rdya", rdy_a, 1);
    tick();
    data_a = 8'h0C; #1;
    chk("bp2_rdya", rdy_a, 1);
    chk("bp2_count", count, 2);
    tick();
    data_a = 8'h0D; #1;
    chk("bp3_rdya", rdy_a, 0);
    chk("bp3_count", count, 3);
    chk("bp3_vldb", vld_b, 1);
    chk("bp3_data", data_b, 8'h0A);
    tick();
    #1;
    chk("bp4_rdya", rdy_a, 0);
    chk("bp4_count", count, 3);
    tick();
    rdy_b = 1'b1; #1;
    chk("bp5_rdya", rdy_a, 0);
    chk("bp5_data", data_b, 8'h0A);
    chk("bp5_count", count, 3);
    tick();
    #1;
    chk("bp6_rdya", rdy_a, 1);
    chk("bp6_data", data_b, 8'h0B);
    chk("bp6_count", count, 2);
    tick();
    vld_a = 1'b0; #1;
    chk("bp7_data", data_b, 8'h0C);
    chk("bp7_count", count, 2);
    tick();
    #1;
    chk("bp8_vldb", vld_b, 1);
    chk("bp8_data", data_b, 8'h0D);
    chk("bp8_count", count, 1);
    tick();
    #1;
    chk("bp9_vldb", vld_b, 0);
    chk("bp9_count", count, 0);

    // Bubble collapse with rdy_b=0
    rdy_b = 1'b0; vld_a = 1'b1; data_a = 8'h05; #1;
    chk("bub0_rdya", rdy_a, 1);
    tick();
    vld_a = 1'b0; #1;
    chk("bub1_vldb", vld_b, 0);
    chk("bub1_count", count, 1);
    tick();
    #1;
    chk("bub2_vldb", vld_b, 1);
    chk("bub2_data", data_b, 8'h05);
    chk("bub2_count", count, 1);
    vld_a = 1'b1; data_a = 8'h06; #1;
    chk("bub2_rdya", rdy_a, 1);
    tick();
    data_a = 8'h07; #1;
    chk("bub3_count", count, 2);
    chk("bub3_rdya", rdy_a, 1);
    chk("bub3_data", data_b, 8'h05);
    tick();

    // Flush with three entries stalled
    #1;
    chk("fl0_count", count, 3);
    flush = 1'b1; data_a = 8'h88; #1;
    chk("fl0_rdya", rdy_a, 0);
    tick();
    flush = 1'b0; rdy_b = 1'b1; data_a = 8'h77; #1;
    chk("fl1_vldb", vld_b, 0);
    chk("fl1_count", count, 0);
    chk("fl1_rdya", rdy_a, 1);
    tick();
    vld_a = 1'b0; #1;
    chk("fl2_vldb", vld_b, 0);
    chk("fl2_count", count, 1);
    tick();
    #1;
    chk("fl3_vldb", vld_b, 1);
    chk("fl3_data", data_b, 8'h77);
    tick();
    #1;
    chk("fl4_vldb", vld_b, 0);
    chk("fl4_count", count, 0);

    // SKID=0: combinational ready chain
    vld_a_0 = 1'b1; data_a_0 = 8'h11; #1;
    chk("s0a_rdya", rdy_a_0, 1);
    tick();
    data_a_0 = 8'h22; #1;
    chk("s0b_rdya", rdy_a_0, 1);
    chk("s0b_count", count_0, 1);
    tick();
    data_a_0 = 8'h33; #1;
    chk("s0c_rdya_full", rdy_a_0, 0);
    chk("s0c_count", count_0, 2);
    chk("s0c_vldb", vld_b_0, 1);
    chk("s0c_data", data_b_0, 8'h11);
    rdy_b_0 = 1'b1; #1;
    chk("s0c_rdya_rise", rdy_a_0, 1);
    tick();
    vld_a_0 = 1'b0; rdy_b_0 = 1'b0; #1;
    chk("s0d_count", count_0, 2);
    chk("s0d_data", data_b_0, 8'h22);
    chk("s0d_rdya", rdy_a_0, 0);
    rdy_b_0 = 1'b1; #1;
    chk("s0d_rdya_rise", rdy_a_0, 1);
    flush_0 = 1'b1; #1;
    chk("s0d_rdya_flush", rdy_a_0, 0);
    tick();
    flush_0 = 1'b0; rdy_b_0 = 1'b0; #1;
    chk("s0e_count", count_0, 0);
    chk("s0e_vldb", vld_b_0, 0);
    chk("s0e_rdya", rdy_a_0, 1);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/pipe_stage_chain.md
PIPE_STAGE_CHAIN -- requirements
Module: pipe_stage_chain

Interface
REQ-001 SHALL have parameter WIDTH, default 32, payload width in bits (>=1).
REQ-002 SHALL have parameter DEPTH, default 2, number of bubble-collapsing register stages (>=1).
REQ-003 SHALL have parameter SKID, default 1: 1 = registered input ready via one-entry skid register; 0 = combinational ready chain.
REQ-004 SHALL have port clk  input  1  single clock; all state updates on rising edge.
REQ-005 SHALL have port rst  input  1  synchronous, active-high reset.
REQ-006 SHALL have port flush  input  1  synchronous discard of all held entries.
REQ-007 SHALL have port data_a  input  WIDTH  upstream payload.
REQ-008 SHALL have port vld_a  input  1  upstream valid.
REQ-009 SHALL have port rdy_a  output  1  ready to upstream.
REQ-010 SHALL have port data_b  output  WIDTH  downstream payload, driven from last stage.
REQ-011 SHALL have port vld_b  output  1  downstream valid, driven from last stage.
REQ-012 SHALL have port rdy_b  input  1  downstream ready.
REQ-013 SHALL have port count  output  $clog2(DEPTH+2)  number of valid entries held (stages plus skid).

Function
REQ-014 SHALL treat a transfer as occurring on a cycle where valid and ready are both 1, on each side independently.
REQ-015 SHALL hold per stage i (0..DEPTH-1) a data register and valid bit; stage DEPTH-1 drives data_b/vld_b directly, no combinational path from data_a to data_b.
REQ-016 SHALL compute stage ready: rdy_s[DEPTH-1] = rdy_b | ~vld[DEPTH-1]; rdy_s[i] = rdy_s[i+1] | ~vld[i]; bubbles collapse even while rdy_b=0.
REQ-017 SHALL, when rdy_s[i]=1, load stage i with upstream stage (stage 0: the stage-0 source) valid, and load data only when that upstream valid is 1; data_b is don't-care while vld_b=0.
REQ-018 SHALL, with SKID=0, use data_a/vld_a as stage-0 source and drive rdy_a = rdy_s[0] combinationally.
REQ-019 SHALL, with SKID=1, drive rdy_a = ~skid_vld, a registered value (flush excepted, REQ-024).
REQ-020 SHALL, with SKID=1 and skid empty, use data_a/vld_a as stage-0 source; on a transfer with rdy_s[0]=0, capture data_a into skid and set skid_vld.
REQ-021 SHALL, with SKID=1 and skid_vld=1, use skid as stage-0 source and clear skid_vld when rdy_s[0]=1; no new input is accepted that cycle.
REQ-022 SHALL have latency DEPTH cycles from input transfer to vld_b when the chain is empty and skid is bypassed; DEPTH+1 for an entry taken via skid.
REQ-023 SHALL sustain one transfer per cycle with rdy_b held 1, no bubbles inserted, order preserved, no loss or duplication.
REQ-024 SHALL, on flush=1, clear all stage valids and skid_vld at the next edge, force rdy_a=0 during that cycle, and emit nothing from the discarded entries; downstream transfer in the flush cycle still completes if vld_b&rdy_b.
REQ-025 SHALL keep count equal to the sum of stage valids plus skid_vld, updated the same edge as the valids; maximum value DEPTH+SKID.

Reset
REQ-026 SHALL, while rst=1 at a clock edge, clear all stage valids, skid_vld and count to 0; data registers to 0.
REQ-027 SHALL, after reset, present vld_b=0, count=0, rdy_a=1 (both SKID settings, rdy_b arbitrary for SKID=1).
REQ-028 SHALL give rst priority over flush and any transfer; entries in flight when rst asserts are discarded.

Verification
REQ-029 SHALL cover reset: DEPTH=2, SKID=1, rst=1 for 2 cycles with vld_a=1 -> vld_b=0, count=0, rdy_a=1 on release, no entry accepted during reset.
REQ-030 SHALL cover streaming: rdy_b=1, data 1..8 on consecutive cycles -> vld_b first high 2 cycles after first transfer, data_b 1..8 on consecutive cycles, rdy_a stays 1.
REQ-031 SHALL cover backpressure: rdy_b=0, offer 0xA,0xB,0xC,0xD -> A,B,C accepted, rdy_a=0 after C, count=3, D held; rdy_b=1 -> A,B,C,D out in order, rdy_a=1 one cycle after skid drains.
REQ-032 SHALL cover bubble collapse: rdy_b=0, one item 0x5 -> in stage 1 (vld_b=1) after 2 cycles; then 0x6 accepted into stage 0, count=2, rdy_a stays 1.
REQ-033 SHALL cover flush: with count=3 stalled, flush=1 one cycle -> rdy_a=0 that cycle, next cycle vld_b=0, count=0, rdy_a=1; next item 0x77 appears at data_b 2 cycles after transfer.
REQ-034 SHALL cover SKID=0: chain full with rdy_b=0 -> rdy_a=0 same cycle; rdy_b rises -> rdy_a=1 same cycle, count never exceeds 2.
